// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// The controller drives the strobes and decode fields and takes the
// instruction fields plus status flags back from the datapath.
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 4
);
  // Instruction register fields and status from the datapath/memory
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               MemReady;

  // One-cycle write/request strobes
  logic               PCWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;

  // Decode fields
  logic               EXTOp;
  logic               ALUSrc;
  logic               ARegSel;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         NPCOp;
  logic [1:0]         GPRSel;
  logic [1:0]         WDSel;

  // Multiply/divide handshake and debug
  logic               MduStart;
  logic               Busy;
  logic [2:0]         State;

  // Controller side
  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    output EXTOp, ALUSrc, ARegSel, ALUOp, NPCOp, GPRSel, WDSel,
    output MduStart, Busy, State
  );

  // Datapath/memory side
  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    input  EXTOp, ALUSrc, ARegSel, ALUOp, NPCOp, GPRSel, WDSel,
    input  MduStart, Busy, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller. Sequences FETCH/DECODE/EXEC/MEM/WB and
// a counted multiply/divide stall. Decode fields are combinational from the
// latched Op/Funct; strobes are derived from the registered state plus the
// same-cycle MemReady/Zero so a memory access completes in the cycle it is
// acknowledged.
module multicycle_ctrl #(
  parameter int ALUOP_W    = 4,   // >= 4, codes are zero-extended
  parameter int MDU_CYCLES = 32,  // 1..255
  parameter int EN_MDU     = 1    // 0 makes mult/div illegal
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SLLV = 4'hA,
    ALU_SRLV = 4'hB,
    ALU_LUI  = 4'hC
  } alu_op_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_SLLV   = 6'b000100;
  localparam logic [5:0] F_SRLV   = 6'b000110;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_JALR   = 6'b001001;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_DIV    = 6'b011010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_NOR    = 6'b100111;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_SLTU   = 6'b101011;

  // Register-file destination select
  localparam logic [1:0] GPR_RD   = 2'b00;
  localparam logic [1:0] GPR_RT   = 2'b01;
  localparam logic [1:0] GPR_RA   = 2'b10;

  // Register write-data select
  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  // Value loaded into the stall counter; MDU_WAIT exits when it reaches 0
  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_mdu_cnt;

  // Instruction classes
  logic        w_r_alu, w_i_alu, w_lw, w_sw, w_beq, w_bne;
  logic        w_j, w_jal, w_jr, w_jalr, w_mdu, w_legal;

  // Decode fields
  alu_op_e     w_alu_op;
  logic        w_ext_op, w_alu_src, w_areg_sel;
  logic [1:0]  w_gpr_sel, w_wd_sel;

  // Strobes
  logic        w_pc_write, w_ir_write, w_reg_write, w_mem_read, w_mem_write;
  logic        w_mdu_start, w_busy;
  logic [1:0]  w_npc_op;

  // Instruction decode: classify Op/Funct and produce datapath select fields
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; an unassigned path would infer a latch.
    w_r_alu    = 1'b0;
    w_i_alu    = 1'b0;
    w_lw       = 1'b0;
    w_sw       = 1'b0;
    w_beq      = 1'b0;
    w_bne      = 1'b0;
    w_j        = 1'b0;
    w_jal      = 1'b0;
    w_jr       = 1'b0;
    w_jalr     = 1'b0;
    w_mdu      = 1'b0;
    w_alu_op   = ALU_NOP;
    w_ext_op   = 1'b0;
    w_alu_src  = 1'b0;
    w_areg_sel = 1'b0;
    w_gpr_sel  = GPR_RD;
    w_wd_sel   = WD_ALU;

    case (bus.Op)
      OP_RTYPE: begin
        case (bus.Funct)
          F_ADD, F_ADDU: begin w_r_alu = 1'b1; w_alu_op = ALU_ADD;  end
          F_SUB, F_SUBU: begin w_r_alu = 1'b1; w_alu_op = ALU_SUB;  end
          F_AND:         begin w_r_alu = 1'b1; w_alu_op = ALU_AND;  end
          F_OR:          begin w_r_alu = 1'b1; w_alu_op = ALU_OR;   end
          F_NOR:         begin w_r_alu = 1'b1; w_alu_op = ALU_NOR;  end
          F_SLT:         begin w_r_alu = 1'b1; w_alu_op = ALU_SLT;  end
          F_SLTU:        begin w_r_alu = 1'b1; w_alu_op = ALU_SLTU; end
          F_SLLV:        begin w_r_alu = 1'b1; w_alu_op = ALU_SLLV; end
          F_SRLV:        begin w_r_alu = 1'b1; w_alu_op = ALU_SRLV; end
          // Fixed shifts take the A operand from the shamt field
          F_SLL: begin
            w_r_alu    = 1'b1;
            w_alu_op   = ALU_SLL;
            w_areg_sel = 1'b1;
          end
          F_SRL: begin
            w_r_alu    = 1'b1;
            w_alu_op   = ALU_SRL;
            w_areg_sel = 1'b1;
          end
          F_JR: w_jr = 1'b1;
          F_JALR: begin
            w_jalr    = 1'b1;
            w_gpr_sel = GPR_RA;
            w_wd_sel  = WD_PC;
          end
          F_MULT, F_DIV: w_mdu = (EN_MDU != 0);
          default: ;
        endcase
      end
      OP_ADDI: begin
        w_i_alu = 1'b1; w_alu_op = ALU_ADD; w_ext_op = 1'b1;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_SLTI: begin
        w_i_alu = 1'b1; w_alu_op = ALU_SLT; w_ext_op = 1'b1;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_ANDI: begin
        w_i_alu = 1'b1; w_alu_op = ALU_AND;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_ORI: begin
        w_i_alu = 1'b1; w_alu_op = ALU_OR;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_LUI: begin
        w_i_alu = 1'b1; w_alu_op = ALU_LUI;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_LW: begin
        w_lw = 1'b1; w_alu_op = ALU_ADD; w_ext_op = 1'b1;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT; w_wd_sel = WD_MEM;
      end
      OP_SW: begin
        w_sw = 1'b1; w_alu_op = ALU_ADD; w_ext_op = 1'b1;
        w_alu_src = 1'b1; w_gpr_sel = GPR_RT;
      end
      OP_BEQ: begin w_beq = 1'b1; w_alu_op = ALU_SUB; w_ext_op = 1'b1; end
      OP_BNE: begin w_bne = 1'b1; w_alu_op = ALU_SUB; w_ext_op = 1'b1; end
      OP_J:   w_j = 1'b1;
      OP_JAL: begin
        w_jal     = 1'b1;
        w_gpr_sel = GPR_RA;
        w_wd_sel  = WD_PC;
      end
      default: ;
    endcase
  end

  // Anything not recognised above retires as a NOP out of DECODE
  assign w_legal = w_r_alu | w_i_alu | w_lw | w_sw | w_beq | w_bne |
                   w_j | w_jal | w_jr | w_jalr | w_mdu;

  // State register and multiply/divide stall counter
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state   <= S_FETCH;
      r_mdu_cnt <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.MemReady) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_j || w_jal || !w_legal) r_state <= S_FETCH;
          else                          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_r_alu || w_i_alu) begin
            r_state <= S_WB;
          end else if (w_lw || w_sw) begin
            r_state <= S_MEM;
          end else if (w_mdu) begin
            r_state   <= S_MDU_WAIT;
            r_mdu_cnt <= MDU_LOAD;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.MemReady) r_state <= w_lw ? S_WB : S_FETCH;
        end
        S_WB: r_state <= S_FETCH;
        S_MDU_WAIT: begin
          if (r_mdu_cnt == 8'd0) r_state   <= S_FETCH;
          else                   r_mdu_cnt <= r_mdu_cnt - 8'd1;
        end
        // Unused codes 6 and 7 recover to FETCH
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes from current state plus same-cycle MemReady/Zero; all held low
  // while rst is high so nothing fires during reset
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mdu_start = 1'b0;
    w_busy      = 1'b0;
    w_npc_op    = NPC_PC4;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read = 1'b1;
          if (bus.MemReady) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_j || w_jal) begin
            w_pc_write  = 1'b1;
            w_npc_op    = NPC_J;
            w_reg_write = w_jal;
          end
        end
        S_EXEC: begin
          if (w_beq || w_bne) begin
            w_pc_write = (w_beq & bus.Zero) | (w_bne & ~bus.Zero);
            w_npc_op   = NPC_BR;
          end
          if (w_jr || w_jalr) begin
            w_pc_write  = 1'b1;
            w_npc_op    = NPC_REG;
            w_reg_write = w_jalr;
          end
          if (w_mdu) w_mdu_start = 1'b1;
        end
        S_MEM: begin
          w_mem_read  = w_lw;
          w_mem_write = w_sw;
        end
        S_WB:       w_reg_write = 1'b1;
        S_MDU_WAIT: w_busy      = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWrite  = w_pc_write;
  assign bus.IRWrite  = w_ir_write;
  assign bus.RegWrite = w_reg_write;
  assign bus.MemRead  = w_mem_read;
  assign bus.MemWrite = w_mem_write;
  assign bus.MduStart = w_mdu_start;
  assign bus.Busy     = w_busy;
  assign bus.NPCOp    = w_npc_op;
  assign bus.EXTOp    = w_ext_op;
  assign bus.ALUSrc   = w_alu_src;
  assign bus.ARegSel  = w_areg_sel;
  assign bus.ALUOp    = ALUOP_W'(w_alu_op);
  assign bus.GPRSel   = w_gpr_sel;
  assign bus.WDSel    = w_wd_sel;
  assign bus.State    = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each task walks one instruction
// cycle by cycle against a hand-written table of
// {MemReady to drive, expected State, expected strobes}.
module tb_multicycle_ctrl;

  localparam int ALUOP_W    = 4;
  localparam int MDU_CYCLES = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ILL   = 6'b111111;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_ILL    = 6'b111111;

  // Strobe vector order: {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MduStart, Busy}
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FETCH = 7'b1101000;
  localparam logic [6:0] SB_MEMRD = 7'b0001000;
  localparam logic [6:0] SB_MEMWR = 7'b0000100;
  localparam logic [6:0] SB_REGWR = 7'b0010000;
  localparam logic [6:0] SB_PC    = 7'b1000000;
  localparam logic [6:0] SB_PC_RW = 7'b1010000;
  localparam logic [6:0] SB_MDU   = 7'b0000010;
  localparam logic [6:0] SB_BUSY  = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if #(.ALUOP_W(ALUOP_W)) bus ();

  multicycle_ctrl #(
    .ALUOP_W   (ALUOP_W),
    .MDU_CYCLES(MDU_CYCLES),
    .EN_MDU    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.MduStart, bus.Busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Op = OP_LW; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({bus.State, strobes()} !== {3'd0, SB_NONE}) begin
      errors++;
      $display("FAIL reset_hold: state/strobes got %0d/%b want 0/%b", bus.State, strobes(), SB_NONE);
    end
    rst = 1'b0; bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.State, strobes()} !== {3'd0, SB_MEMRD}) begin
      errors++;
      $display("FAIL reset_release: state/strobes got %0d/%b want 0/%b", bus.State, strobes(), SB_MEMRD);
    end
  endtask

  task automatic test_addi();
    logic [10:0] seq [4];
    seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE},
            {1'b0, 3'd2, SB_NONE},  {1'b1, 3'd4, SB_REGWR}};
    bus.Op = OP_ADDI; bus.Funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = seq[i][10];
      #1;
      checks++;
      if ({bus.State, strobes()} !== seq[i][9:0]) begin
        errors++;
        $display("FAIL addi[%0d]: state/strobes got %0d/%b want %0d/%b", i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
      end
      if (i == 3) begin
        checks++;
        if ({bus.ALUOp, bus.GPRSel, bus.EXTOp, bus.ALUSrc, bus.WDSel} !== {4'h1, 2'b01, 1'b1, 1'b1, 2'b00}) begin
          errors++;
          $display("FAIL addi_decode: ALUOp/GPRSel/EXTOp/ALUSrc/WDSel got %h/%b/%b/%b/%b want 1/01/1/1/00",
                   bus.ALUOp, bus.GPRSel, bus.EXTOp, bus.ALUSrc, bus.WDSel);
        end
      end
      tick();
    end
    checks++;
    if (bus.State !== 3'd0) begin
      errors++;
      $display("FAIL addi_return: state got %0d want 0", bus.State);
    end
  endtask

  task automatic test_lw();
    logic [10:0] seq [8];
    int rd_cycles;
    seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE},  {1'b0, 3'd2, SB_NONE},
            {1'b0, 3'd3, SB_MEMRD}, {1'b0, 3'd3, SB_MEMRD}, {1'b0, 3'd3, SB_MEMRD},
            {1'b1, 3'd3, SB_MEMRD}, {1'b0, 3'd4, SB_REGWR}};
    rd_cycles = 0;
    bus.Op = OP_LW; bus.Funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      bus.MemReady = seq[i][10];
      #1;
      checks++;
      if ({bus.State, strobes()} !== seq[i][9:0]) begin
        errors++;
        $display("FAIL lw[%0d]: state/strobes got %0d/%b want %0d/%b", i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
      end
      if (bus.State == 3'd3 && bus.MemRead) rd_cycles++;
      if (i == 7) begin
        checks++;
        if ({bus.WDSel, bus.GPRSel} !== {2'b01, 2'b01}) begin
          errors++;
          $display("FAIL lw_wb_sel: WDSel/GPRSel got %b/%b want 01/01", bus.WDSel, bus.GPRSel);
        end
      end
      tick();
    end
    checks++;
    if (bus.State !== 3'd0) begin
      errors++;
      $display("FAIL lw_return: state got %0d want 0 after 8 cycles", bus.State);
    end
    checks++;
    if (rd_cycles !== 4) begin
      errors++;
      $display("FAIL lw_memread_len: MemRead cycles in MEM got %0d want 4", rd_cycles);
    end
  endtask

  task automatic test_sw();
    logic [10:0] seq [5];
    seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE}, {1'b0, 3'd2, SB_NONE},
            {1'b0, 3'd3, SB_MEMWR}, {1'b1, 3'd3, SB_MEMWR}};
    bus.Op = OP_SW; bus.Funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      bus.MemReady = seq[i][10];
      #1;
      checks++;
      if ({bus.State, strobes()} !== seq[i][9:0]) begin
        errors++;
        $display("FAIL sw[%0d]: state/strobes got %0d/%b want %0d/%b", i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
      end
      tick();
    end
    checks++;
    if (bus.State !== 3'd0) begin
      errors++;
      $display("FAIL sw_return: state got %0d want 0", bus.State);
    end
  endtask

  task automatic test_branch();
    logic [10:0] seq [3];
    for (int z = 0; z < 2; z++) begin
      seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE},
              {1'b0, 3'd2, (z == 1) ? SB_PC : SB_NONE}};
      bus.Op = OP_BEQ; bus.Funct = 6'd0; bus.Zero = (z == 1);
      for (int i = 0; i < 3; i++) begin
        bus.MemReady = seq[i][10];
        #1;
        checks++;
        if ({bus.State, strobes()} !== seq[i][9:0]) begin
          errors++;
          $display("FAIL beq_z%0d[%0d]: state/strobes got %0d/%b want %0d/%b", z, i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
        end
        if (i == 2 && z == 1) begin
          checks++;
          if ({bus.NPCOp, bus.ALUOp} !== {2'b01, 4'h2}) begin
            errors++;
            $display("FAIL beq_npc: NPCOp/ALUOp got %b/%h want 01/2", bus.NPCOp, bus.ALUOp);
          end
        end
        tick();
      end
      checks++;
      if (bus.State !== 3'd0) begin
        errors++;
        $display("FAIL beq_z%0d_return: state got %0d want 0", z, bus.State);
      end
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [10:0] seq [3];
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        bus.Op = OP_JAL; bus.Funct = 6'd0; n = 2;
        seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_PC_RW}, {1'b0, 3'd0, SB_NONE}};
      end else begin
        bus.Op = OP_RTYPE; bus.Funct = F_JR; n = 3;
        seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE}, {1'b0, 3'd2, SB_PC}};
      end
      for (int i = 0; i < n; i++) begin
        bus.MemReady = seq[i][10];
        #1;
        checks++;
        if ({bus.State, strobes()} !== seq[i][9:0]) begin
          errors++;
          $display("FAIL jump%0d[%0d]: state/strobes got %0d/%b want %0d/%b", k, i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
        end
        if (k == 0 && i == 1) begin
          checks++;
          if ({bus.NPCOp, bus.GPRSel, bus.WDSel} !== 6'b101010) begin
            errors++;
            $display("FAIL jal_sel: NPCOp/GPRSel/WDSel got %b/%b/%b want 10/10/10", bus.NPCOp, bus.GPRSel, bus.WDSel);
          end
        end
        if (k == 1 && i == 2) begin
          checks++;
          if (bus.NPCOp !== 2'b11) begin
            errors++;
            $display("FAIL jr_npc: NPCOp got %b want 11", bus.NPCOp);
          end
        end
        tick();
      end
      checks++;
      if (bus.State !== 3'd0) begin
        errors++;
        $display("FAIL jump%0d_return: state got %0d want 0", k, bus.State);
      end
    end
  endtask

  task automatic test_mult();
    logic [10:0] seq [7];
    int starts;
    int busy_cycles;
    seq = '{{1'b1, 3'd0, SB_FETCH}, {1'b0, 3'd1, SB_NONE}, {1'b0, 3'd2, SB_MDU},
            {1'b0, 3'd5, SB_BUSY},  {1'b0, 3'd5, SB_BUSY}, {1'b0, 3'd5, SB_BUSY},
            {1'b0, 3'd5, SB_BUSY}};
    starts = 0;
    busy_cycles = 0;
    bus.Op = OP_RTYPE; bus.Funct = F_MULT;
    for (int i = 0; i < 7; i++) begin
      bus.MemReady = seq[i][10];
      #1;
      checks++;
      if ({bus.State, strobes()} !== seq[i][9:0]) begin
        errors++;
        $display("FAIL mult[%0d]: state/strobes got %0d/%b want %0d/%b", i, bus.State, strobes(), seq[i][9:7], seq[i][6:0]);
      end
      if (bus.MduStart) starts++;
      if (bus.Busy) busy_cycles++;
      tick();
    end
    checks++;
    if ({bus.State, bus.Busy} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mult_return: state/busy got %0d/%b want 0/0", bus.State, bus.Busy);
    end
    checks++;
    if (starts !== 1 || busy_cycles !== MDU_CYCLES) begin
      errors++;
      $display("FAIL mult_counts: MduStart pulses %0d want 1, Busy cycles %0d want %0d", starts, busy_cycles, MDU_CYCLES);
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin bus.Op = OP_ILL;   bus.Funct = 6'd0;  end
      else        begin bus.Op = OP_RTYPE; bus.Funct = F_ILL; end
      bus.MemReady = 1'b1;
      #1;
      tick();
      bus.MemReady = 1'b0;
      #1;
      checks++;
      if ({bus.State, strobes()} !== {3'd1, SB_NONE}) begin
        errors++;
        $display("FAIL illegal%0d_decode: state/strobes got %0d/%b want 1/%b", k, bus.State, strobes(), SB_NONE);
      end
      tick();
      checks++;
      if ({bus.State, strobes()} !== {3'd0, SB_MEMRD}) begin
        errors++;
        $display("FAIL illegal%0d_return: state/strobes got %0d/%b want 0/%b", k, bus.State, strobes(), SB_MEMRD);
      end
    end
  endtask

  // Reset in the second MDU_WAIT cycle, then in the second cycle of a stalled sw
  task automatic test_reset_mid_op();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin bus.Op = OP_RTYPE; bus.Funct = F_MULT; end
      else        begin bus.Op = OP_SW;    bus.Funct = 6'd0;   end
      bus.MemReady = 1'b1;
      #1;
      tick();
      bus.MemReady = 1'b0;
      tick();
      tick();
      tick();
      #1;
      checks++;
      if ({bus.State, strobes()} !== ((k == 0) ? {3'd5, SB_BUSY} : {3'd3, SB_MEMWR})) begin
        errors++;
        $display("FAIL midop%0d_pre: state/strobes got %0d/%b", k, bus.State, strobes());
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.State, strobes()} !== {3'd0, SB_NONE}) begin
        errors++;
        $display("FAIL midop%0d_during: state/strobes got %0d/%b want 0/%b", k, bus.State, strobes(), SB_NONE);
      end
      tick();
      checks++;
      if ({bus.State, strobes()} !== {3'd0, SB_NONE}) begin
        errors++;
        $display("FAIL midop%0d_after_edge: state/strobes got %0d/%b want 0/%b", k, bus.State, strobes(), SB_NONE);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.State, strobes()} !== {3'd0, SB_MEMRD}) begin
        errors++;
        $display("FAIL midop%0d_release: state/strobes got %0d/%b want 0/%b", k, bus.State, strobes(), SB_MEMRD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_mult();
    test_illegal();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
